// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared encodings, state type and constants for the iterative divider
package div_unit_pkg;

    // div_op encodings: bit 0 selects unsigned, bit 1 selects remainder
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DIVIDE = 2'b01,
        S_FIXUP  = 2'b10,
        S_DONE   = 2'b11
    } div_state_t;

    localparam int          DIV_STEPS    = 32;
    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_QUO  = 32'h8000_0000;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Ports:
//   rem      in  32  partial remainder before the step
//   quo      in  32  quotient shift register before the step (dividend bits still at the top)
//   divisor  in  32  divisor magnitude
//   rem_nxt  out 32  partial remainder after the step
//   quo_nxt  out 32  quotient shift register after the step
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_nxt,
    output logic [31:0] quo_nxt
);

    logic [32:0] shifted;
    logic [33:0] trial;
    logic        fits;

    // The shifted remainder can reach 2*divisor-1, so the subtraction is
    // carried one bit wider than the operands to keep its sign unambiguous.
    always_comb begin
        shifted = {rem, quo[31]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        fits    = ~trial[33];
        rem_nxt = fits ? trial[31:0] : shifted[31:0];
        quo_nxt = {quo[30:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU) with fast special-case path
//
// Ports:
//   clk     in  1   clock
//   reset   in  1   asynchronous active-high reset
//   start   in  1   operation request, honoured only in IDLE
//   div_op  in  2   operation select (see div_op_t)
//   a       in  32  dividend, sampled with start
//   b       in  32  divisor, sampled with start
//   flush   in  1   abort any operation in progress
//   busy    out 1   operation in flight
//   done    out 1   one-cycle result-valid pulse
//   result  out 32  quotient or remainder, held until the next accepted start completes
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  div_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_t  state, state_nxt;

    logic [1:0]  op_r;
    logic [31:0] rem_r, quo_r, dvs_r, res_r;
    logic [5:0]  cnt_r;
    logic        qsign_r, rsign_r;

    logic        accept, sgn, dz, ovf, fin;
    logic [31:0] a_mag, b_mag, fast_res;
    logic [31:0] step_rem, step_quo, quo_fix, rem_fix;

    div_step u_step (
        .rem     (rem_r),
        .quo     (quo_r),
        .divisor (dvs_r),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    always_comb begin
        accept = (state == S_IDLE) && start && !flush;
        sgn    = op_is_signed(div_op);
        a_mag  = (sgn && a[31]) ? -a : a;
        b_mag  = (sgn && b[31]) ? -b : b;
        dz     = (b == 32'd0);
        ovf    = sgn && (a == DIV_OVF_QUO) && (b == 32'hFFFF_FFFF);
        // Divide-by-zero returns the raw dividend as remainder, not its magnitude
        if (dz)
            fast_res = op_is_rem(div_op) ? a : DIV_ZERO_QUO;
        else
            fast_res = op_is_rem(div_op) ? 32'd0 : DIV_OVF_QUO;
        quo_fix = ((op_r == DIV_OP_DIV) && qsign_r) ? -quo_r : quo_r;
        rem_fix = ((op_r == DIV_OP_REM) && rsign_r) ? -rem_r : rem_r;
        fin     = (state == S_DONE) && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = (dz || ovf) ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (cnt_r == 6'(DIV_STEPS - 1)) state_nxt = S_FIXUP;
            S_FIXUP:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (flush && (state != S_IDLE))
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= 2'b00;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            dvs_r   <= 32'd0;
            res_r   <= 32'd0;
            cnt_r   <= 6'd0;
            qsign_r <= 1'b0;
            rsign_r <= 1'b0;
        end else begin
            if (accept) begin
                op_r    <= div_op;
                dvs_r   <= b_mag;
                qsign_r <= sgn && (a[31] ^ b[31]);
                rsign_r <= sgn && a[31];
                rem_r   <= 32'd0;
                quo_r   <= a_mag;
                cnt_r   <= 6'd0;
                if (dz || ovf)
                    res_r <= fast_res;
            end else if (state == S_DIVIDE) begin
                rem_r <= step_rem;
                quo_r <= step_quo;
                cnt_r <= cnt_r + 6'd1;
            end else if (state == S_FIXUP) begin
                res_r <= op_is_rem(op_r) ? rem_fix : quo_fix;
            end
        end
    end

    // Outputs are registered; result only moves on a completed operation so a
    // flush leaves the previous value visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= fin;
            if (fin)
                result <= res_r;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .div_op (div_op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0)
            return op[1] ? x : 32'hFFFF_FFFF;
        if (op[0]) begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        q = sx / sy;
        r = sx % sy;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 2;
        if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Issues one op and reports the result, cycles from the accepting edge to
    // done, and the number of cycles busy was seen high.
    task automatic do_op(input logic [1:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        div_op = op; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; bcnt = 0; res = 32'hx;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL op_timeout actual=no_done required=done");
        end else begin
            @(negedge clk);
            chk("done_width", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r, ra, rb;
        logic [1:0]  rop;
        int lat, bc, ndone, dk, elat;

        vt[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         35};
        vt[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          35};
        vt[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35};
        vt[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35};
        vt[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          35};
        vt[5]  = '{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  2};
        vt[6]  = '{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  2};
        vt[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
        vt[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};
        vt[9]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
        vt[10] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  2};
        vt[11] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         35};

        #1 reset = 1'b1;
        #2;
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_result", result,        32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, r, lat, bc);
            chk($sformatf("vec%0d_result", i), r, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bc, vt[i].lat - 1);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (i == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rop = 2'b00; end
            do_op(rop, ra, rb, r, lat, bc);
            elat = ref_lat(rop, ra, rb);
            chk($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), r, ref_div(rop, ra, rb));
            chk($sformatf("rand%0d_latency", i), lat, elat);
        end

        // start held for 40 cycles; operands change mid-operation
        @(negedge clk);
        div_op = 2'b01; a = 32'd1000; b = 32'd10; start = 1'b1;
        @(posedge clk);
        ndone = 0; dk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) begin a = 32'd77; b = 32'd3; end
            if (done) begin
                ndone++;
                dk = k;
                chk("held_result", result, 32'd100);
            end
            if (k == 36) chk("held_back_to_back_busy", {31'd0, busy}, 32'd1);
        end
        chk("held_done_count", ndone, 32'd1);
        chk("held_done_cycle", dk, 32'd35);
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("held_flush_busy", {31'd0, busy}, 32'd0);

        // flush and start together in IDLE: start is dropped
        @(negedge clk);
        div_op = 2'b01; a = 32'd8; b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("idle_flush_no_activity", ndone, 32'd0);

        // flush mid-DIVIDE: no done, result keeps previous value
        do_op(2'b01, 32'd1000, 32'd10, r, lat, bc);
        chk("pre_flush_result", r, 32'd100);
        @(negedge clk);
        div_op = 2'b00; a = 32'd50; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_drop", {31'd0, busy}, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("flush_no_done", ndone, 32'd0);
        chk("flush_result_held", result, 32'd100);
        do_op(2'b01, 32'd9, 32'd3, r, lat, bc);
        chk("post_flush_result", r, 32'd3);

        // asynchronous reset mid-DIVIDE
        @(negedge clk);
        div_op = 2'b01; a = 32'd12345; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_busy",   {31'd0, busy}, 32'd0);
        chk("async_reset_done",   {31'd0, done}, 32'd0);
        chk("async_reset_result", result,        32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("async_reset_no_done", ndone, 32'd0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, r, lat, bc);
        chk("post_reset_result", r, 32'hFFFF_FFFF);
        chk("post_reset_latency", lat, 32'd35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, in the Execute stage beside the single-cycle ALU. The ALU is a combinational responder. This block is the multi-cycle responder the pipeline needs for division. It accepts one operation on a start pulse, holds busy for the stall controller, and returns the result with a one-cycle done pulse. RISC-V special cases (divide-by-zero, signed overflow) complete on a fast path without iterating.

## Interface
- No parameters; operand width is fixed at 32.
- One clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous active-high reset; forces IDLE and clears all outputs.
- start  in  1  request; sampled only in IDLE.
- div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  in  32  dividend; sampled with start.
- b  in  32  divisor; sampled with start.
- flush  in  1  pipeline flush; aborts any operation in progress.
- busy  out  1  high from the cycle after start is accepted until done is asserted; reset 0.
- done  out  1  one-cycle pulse when result is valid; reset 0.
- result  out  32  quotient or remainder; held from done until the next accepted start; reset 0.

## Operation
- States: IDLE, DIVIDE, FIXUP, DONE.
- IDLE, start=1: latch div_op, a, b.
  - Signed ops (DIV, REM): latch |a| and |b|, plus quotient sign (a[31]^b[31]) and remainder sign (a[31]).
  - b==0 or signed overflow: go to DONE.
  - Otherwise: clear remainder register, load the dividend into the quotient shift register, clear the 6-bit counter, go to DIVIDE.
- DIVIDE: one restoring step per cycle, MSB first.
  - Shift {rem, quo} left by 1.
  - Compute 33-bit trial = rem - divisor.
  - If trial is non-negative: rem = trial and set quo LSB.
  - The counter increments each step. After step 32 (counter 31 -> 32), go to FIXUP.
- FIXUP:
  - Negate the quotient if its sign is set and the op is DIV.
  - Negate the remainder if its sign is set and the op is REM.
  - Select the quotient or remainder into result, go to DONE.
- DONE: assert done for one cycle, deassert busy, go to IDLE.
- Divide-by-zero result: quotient 0xFFFFFFFF (all ones, both signed and unsigned); remainder = a unmodified.
- Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Signed result rules: the quotient truncates toward zero; the remainder takes the sign of the dividend.
- start while busy: ignored; the operation in flight is unaffected.
- start in the DONE cycle: ignored; it is accepted only on a later IDLE cycle.
- flush in any state other than IDLE: go to IDLE next edge.
  - busy drops next cycle; done is never pulsed; result keeps its previous value.
  - flush and start together in IDLE: flush wins and the start is dropped.
- reset mid-operation: immediate IDLE; busy, done and result go to 0; no done is produced.

## Timing
- Start accepted at edge E0.
- Normal path:
  - DIVIDE occupies cycles E1..E32.
  - FIXUP occupies E33; result and done become visible after E34.
  - busy is high for 34 cycles, with done in the first cycle after busy falls.
  - Back-to-back: the next start is accepted at E35 at the earliest, giving 35 cycles per operation.
- Fast path (b==0 or overflow):
  - busy is high for one cycle.
  - done and result appear two cycles after start.
- done is exactly one cycle wide.
- result is registered; there is no combinational path from any input to any output.

## Structure
- Shared package (alongside the existing ALU control encodings):
  - div_op encodings: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
  - State enum div_state_t.
  - Constants DIV_STEPS=32, DIV_ZERO_QUO=32'hFFFFFFFF, DIV_OVF_QUO=32'h80000000.
- One sub-module, div_step:
  - Combinational.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem and quo for one restoring iteration.
- The FSM, counter, sign handling and fixup stay in div_unit.

## Test plan
- DIVU a=100, b=7 -> after 34 busy cycles, one done pulse with result=14; REMU same operands -> result=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM a=7, b=-2 -> 1.
- DIVU a=0x12345678, b=0 -> result 0xFFFFFFFF; REMU same -> 0x12345678; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0. Each checks fast-path timing: busy 1 cycle, done two cycles after start.
- Hold start high for 40 cycles with DIVU 1000/10 -> exactly one done (result 100). Change a and b at cycle 5 of the operation -> the result is unaffected.
- Assert flush at cycle 10 of DIV 50/5 -> busy low the next cycle, no done, result keeps its prior value. Then DIVU 9/3 completes -> result 3.
- Assert reset asynchronously mid-DIVIDE -> busy, done and result read 0 before the next clock edge. After release, DIVU 0xFFFFFFFF/1 -> result 0xFFFFFFFF.
